bcd_digit_entry: RTL

//   Builds a 13-digit packed-BCD operand from single-digit key events; supports backspace, clear and commit.

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_digit_entry.sv | 133 +++++++++++++
 2 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and types for the BCD operand entry path.
// Holds the default operand width, the key-code map and the entry FSM state type.
// Imported by bcd_digit_entry; the parent converter only needs DIGITS.
package bcd_pkg;

  // Default number of BCD digits in an operand.
  localparam int DIGITS = 13;

  // Key codes from the key decoder. 0-9 are digits; 0xD-0xF are unused.
  localparam logic [3:0] KEY_DIG_MAX = 4'h9;
  localparam logic [3:0] KEY_BKSP    = 4'hA;
  localparam logic [3:0] KEY_CLR     = 4'hB;
  localparam logic [3:0] KEY_ENT     = 4'hC;

  // ENTRY: building an operand. HOLD: committed operand waiting for downstream.
  typedef enum logic {
    ENTRY = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_digit_entry.sv
// Builds a DIGITS-wide packed-BCD operand from key events (digit, backspace, clear, enter).
// Latency: a key accepted on a rising edge is visible on disp_bcd/digit_count/out_* one cycle later.
// Backpressure: key_ready drops while a committed operand waits; keys are dropped, not queued.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   key_valid    key strobe, accepted when key_ready=1
//   key_code     0-9 digit, 0xA backspace, 0xB clear, 0xC enter, 0xD-0xF ignored
//   key_ready    high in ENTRY state (pure registered-state decode)
//   disp_bcd     live entry, digit 0 (least significant) in [3:0]
//   digit_count  significant digits entered, 0..DIGITS
//   full_err     one-cycle pulse after a digit was dropped because the entry was full
//   out_bcd      committed operand, stable while out_valid=1
//   out_valid    committed operand available
//   out_ready    downstream accepts out_bcd
module bcd_digit_entry #(
  parameter int DIGITS = bcd_pkg::DIGITS,
  parameter int CNT_W  = $clog2(DIGITS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  output logic                key_ready,
  output logic [4*DIGITS-1:0] disp_bcd,
  output logic [CNT_W-1:0]    digit_count,
  output logic                full_err,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic                out_valid,
  input  logic                out_ready
);
  import bcd_pkg::*;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIGITS);

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [4*DIGITS-1:0] out_q, out_d;
  logic                ov_q, ov_d;
  logic                ferr_q, ferr_d;
  logic                key_acc;

  // key_ready depends only on registered state, so out_ready never reaches it.
  assign key_ready = (state_q == ENTRY);
  assign key_acc   = key_valid & key_ready;

  always_comb begin
    state_d = state_q;
    disp_d  = disp_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    ov_d    = ov_q;
    ferr_d  = 1'b0;

    case (state_q)
      ENTRY: begin
        if (key_acc) begin
          if (key_code <= KEY_DIG_MAX) begin
            if (cnt_q == CNT_FULL) begin
              // Entry full: drop the digit and flag it for one cycle.
              ferr_d = 1'b1;
            end else if ((cnt_q != '0) || (key_code != 4'd0)) begin
              // A zero typed into an empty entry is a leading zero and is not counted.
              disp_d = {disp_q[4*DIGITS-5:0], key_code};
              cnt_d  = cnt_q + CNT_W'(1);
            end
          end else begin
            case (key_code)
              KEY_BKSP: begin
                if (cnt_q != '0) begin
                  disp_d = disp_q >> 4;
                  cnt_d  = cnt_q - CNT_W'(1);
                end
              end
              KEY_CLR: begin
                disp_d = '0;
                cnt_d  = '0;
              end
              KEY_ENT: begin
                // An empty entry commits the value zero.
                out_d   = disp_q;
                ov_d    = 1'b1;
                disp_d  = '0;
                cnt_d   = '0;
                state_d = HOLD;
              end
              default: begin
              end
            endcase
          end
        end
      end
      HOLD: begin
        // out_valid is always set in HOLD, so out_ready alone completes the handshake.
        // out_bcd keeps its value after the handshake.
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = ENTRY;
        end
      end
      default: begin
        state_d = ENTRY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ENTRY;
      disp_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      ov_q    <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ov_q    <= ov_d;
      ferr_q  <= ferr_d;
    end
  end

  assign disp_bcd    = disp_q;
  assign digit_count = cnt_q;
  assign out_bcd     = out_q;
  assign out_valid   = ov_q;
  assign full_err    = ferr_q;

endmodule
